// File: rtl/sap_prog_ram.sv
// Single-port program/data RAM with synchronous CPU access, a streaming loader and an optional clear sweep.
// Optional feature macro: SAP_PROG_RAM_PARITY_EN (per-word even parity, err_inject_i / parity_err_o ports).
module sap_prog_ram #(
  parameter int unsigned DATA_W        = 8,
  parameter int unsigned ADDR_W        = 4,
  parameter bit          CLEAR_ON_PROG = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cen_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o,
  output logic              rvalid_o,
  input  logic              prog_start_i,
  input  logic              prog_valid_i,
  input  logic [DATA_W-1:0] prog_data_i,
  input  logic              prog_last_i,
  output logic              prog_ready_o,
  output logic              busy_o,
  output logic [ADDR_W:0]   prog_count_o
`ifdef SAP_PROG_RAM_PARITY_EN
  ,
  input  logic              err_inject_i,
  output logic              parity_err_o
`endif
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;
`ifdef SAP_PROG_RAM_PARITY_EN
  localparam int unsigned MEM_W = DATA_W + 1;
`else
  localparam int unsigned MEM_W = DATA_W;
`endif
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {ST_RUN, ST_CLEAR, ST_PROG} state_t;

  state_t              state, state_next;
  logic [ADDR_W-1:0]   ptr, ptr_next;
  logic [CNT_W-1:0]    cnt_next;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [MEM_W-1:0]    mem_word;
  logic                rd_en;
  logic [MEM_W-1:0]    mem [DEPTH];

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= ST_RUN;
    else       state <= state_next;
  end

  // Next state, pointer/count update and the single write port mux
  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    cnt_next   = prog_count_o;
    mem_we     = 1'b0;
    mem_addr   = addr_i;
    mem_wdata  = data_i;
    rd_en      = 1'b0;
    case (state)
      ST_RUN: begin
        rd_en  = cen_i & ~we_i;
        mem_we = cen_i & we_i;
        if (prog_start_i) begin
          ptr_next   = '0;
          cnt_next   = '0;
          state_next = CLEAR_ON_PROG ? ST_CLEAR : ST_PROG;
        end
      end
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_addr  = ptr;
        mem_wdata = '0;
        ptr_next  = ptr + ADDR_W'(1);
        if (ptr == LAST_ADDR) begin
          ptr_next   = '0;
          state_next = ST_PROG;
        end
      end
      ST_PROG: begin
        if (prog_valid_i) begin
          mem_we    = 1'b1;
          mem_addr  = ptr;
          mem_wdata = prog_data_i;
          cnt_next  = prog_count_o + CNT_W'(1);
          // Top address saturates the pointer and ends the session
          if (ptr == LAST_ADDR) begin
            state_next = ST_RUN;
          end else begin
            ptr_next = ptr + ADDR_W'(1);
            if (prog_last_i) state_next = ST_RUN;
          end
        end
      end
      default: state_next = ST_RUN;
    endcase
  end

`ifdef SAP_PROG_RAM_PARITY_EN
  assign mem_word = {(^mem_wdata) ^ err_inject_i, mem_wdata};
`else
  assign mem_word = mem_wdata;
`endif

  // Storage array: never reset, writes suppressed during reset
  always_ff @(posedge clk_i) begin
    if (mem_we && !rst_i) mem[mem_addr] <= mem_word;
  end

  // Registered outputs and loader bookkeeping
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr          <= '0;
      prog_count_o <= '0;
      data_o       <= '0;
      rvalid_o     <= 1'b0;
      prog_ready_o <= 1'b0;
      busy_o       <= 1'b0;
`ifdef SAP_PROG_RAM_PARITY_EN
      parity_err_o <= 1'b0;
`endif
    end else begin
      ptr          <= ptr_next;
      prog_count_o <= cnt_next;
      rvalid_o     <= rd_en;
      prog_ready_o <= (state_next == ST_PROG);
      busy_o       <= (state_next != ST_RUN);
      if (rd_en) data_o <= mem[addr_i][DATA_W-1:0];
`ifdef SAP_PROG_RAM_PARITY_EN
      parity_err_o <= rd_en & (^mem[addr_i]);
`endif
    end
  end

endmodule

// File: tb/tb_sap_prog_ram.sv
// Self-checking bench for sap_prog_ram: directed load/overflow/lockout/reset sequences,
// a CPU access vector table and a randomized run against a cycle-level reference model.
module tb_sap_prog_ram;

  localparam int unsigned DW    = 8;
  localparam int unsigned AW    = 4;
  localparam int          DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst, cen, we, start, pvalid, plast;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata, pdata;
  logic [DW-1:0] data_o;
  logic          rvalid, ready, busy;
  logic [AW:0]   cnt;
`ifdef SAP_PROG_RAM_PARITY_EN
  logic          err_inject, parity_err;
`endif

  always #5 clk = ~clk;

  sap_prog_ram #(.DATA_W(DW), .ADDR_W(AW), .CLEAR_ON_PROG(1'b1)) dut (
    .clk_i(clk), .rst_i(rst), .cen_i(cen), .we_i(we), .addr_i(addr), .data_i(wdata),
    .data_o(data_o), .rvalid_o(rvalid), .prog_start_i(start), .prog_valid_i(pvalid),
    .prog_data_i(pdata), .prog_last_i(plast), .prog_ready_o(ready), .busy_o(busy),
    .prog_count_o(cnt)
`ifdef SAP_PROG_RAM_PARITY_EN
    , .err_inject_i(err_inject), .parity_err_o(parity_err)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: memory image plus a simple session description
  logic [DW-1:0] m_mem [DEPTH];
  bit            m_known [DEPTH];
  int            m_clear_left, m_ptr, m_cnt;
  bit            m_prog, m_rvalid, m_data_known;
  logic [DW-1:0] m_data;

  typedef struct {
    logic          cen;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] d;
    logic          rv;
    logic [DW-1:0] exp_d;
  } vec_t;
  vec_t tbl [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    if (rst) begin
      m_clear_left = 0; m_prog = 0; m_ptr = 0; m_cnt = 0;
      m_data = '0; m_data_known = 1; m_rvalid = 0;
    end else begin
      m_rvalid = 0;
      if (m_clear_left > 0) begin
        m_mem[m_ptr] = '0; m_known[m_ptr] = 1;
        m_ptr++; m_clear_left--;
        if (m_clear_left == 0) begin m_ptr = 0; m_prog = 1; end
      end else if (m_prog) begin
        if (pvalid) begin
          m_mem[m_ptr] = pdata; m_known[m_ptr] = 1;
          m_ptr++; m_cnt++;
          if (plast || m_cnt == DEPTH) m_prog = 0;
        end
      end else begin
        if (cen && we) begin
          m_mem[addr] = wdata; m_known[addr] = 1;
        end else if (cen) begin
          m_data = m_mem[addr]; m_data_known = m_known[addr]; m_rvalid = 1;
        end
        if (start) begin
          m_ptr = 0; m_cnt = 0; m_clear_left = DEPTH;
        end
      end
    end
  endtask

  // One clock: advance the model, take the edge, compare every output
  task automatic tick();
    logic exp_busy, exp_ready;
    model_step();
    @(posedge clk);
    #1;
    exp_busy  = (m_clear_left > 0) || m_prog;
    exp_ready = m_prog;
    check("ctrl{busy,ready,rvalid,count}", 32'({busy, ready, rvalid, cnt}),
          32'({exp_busy, exp_ready, m_rvalid, 5'(m_cnt)}));
    if (m_data_known) check("model_data", 32'(data_o), 32'(m_data));
`ifdef SAP_PROG_RAM_PARITY_EN
    if (!rvalid) check("parity_idle", 32'(parity_err), 32'd0);
`endif
  endtask

  task automatic drive(input bit r, input bit c, input bit w, input int a, input int d,
                       input bit s, input bit v, input int pd, input bit l);
    rst = r; cen = c; we = w; addr = AW'(a); wdata = DW'(d);
    start = s; pvalid = v; pdata = DW'(pd); plast = l;
    tick();
  endtask

  task automatic idle();                    drive(0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic rd(input int a);           drive(0, 1, 0, a, 0, 0, 0, 0, 0); endtask
  task automatic wr(input int a, input int d); drive(0, 1, 1, a, d, 0, 0, 0, 0); endtask
  task automatic push(input int d, input bit l); drive(0, 0, 0, 0, 0, 0, 1, d, l); endtask
  task automatic begin_load();              drive(0, 0, 0, 0, 0, 1, 0, 0, 0); endtask

  initial begin : main
    logic [DW-1:0] img [13];
    img = '{8'h09, 8'h1A, 8'h1B, 8'h2C, 8'hE0, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h10, 8'h14, 8'h18, 8'h20};
    tbl[0] = '{1'b1, 1'b1, 4'd7,  8'hA5, 1'b0, 8'h10};
    tbl[1] = '{1'b1, 1'b0, 4'd7,  8'h00, 1'b1, 8'hA5};
    tbl[2] = '{1'b0, 1'b0, 4'd0,  8'h00, 1'b0, 8'hA5};
    tbl[3] = '{1'b1, 1'b1, 4'd3,  8'h5A, 1'b0, 8'hA5};
    tbl[4] = '{1'b1, 1'b0, 4'd3,  8'h00, 1'b1, 8'h5A};
    tbl[5] = '{1'b1, 1'b0, 4'd15, 8'h00, 1'b1, 8'h10};
    tbl[6] = '{1'b1, 1'b0, 4'd7,  8'h00, 1'b1, 8'hA5};
    tbl[7] = '{1'b0, 1'b1, 4'd2,  8'hFF, 1'b0, 8'hA5};
    tbl[8] = '{1'b1, 1'b0, 4'd2,  8'h00, 1'b1, 8'h03};
    for (int i = 0; i < DEPTH; i++) begin m_known[i] = 0; m_mem[i] = '0; end
`ifdef SAP_PROG_RAM_PARITY_EN
    err_inject = 1'b0;
`endif

    // Reset state
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    check("reset_outputs", 32'({data_o, rvalid, ready, busy, cnt}), 32'd0);

    // Load with clear sweep, 13-word image
    begin_load();
    check("clear_busy", 32'({busy, ready}), 32'b10);
    for (int i = 0; i < DEPTH; i++) idle();
    check("prog_ready_after_clear", 32'(ready), 32'd1);
    for (int i = 0; i < 13; i++) push(int'(img[i]), i == 12);
    check("load_count", 32'(cnt), 32'd13);
    check("load_idle", 32'({busy, ready}), 32'b00);
    rd(3);
    check("load_rd3", 32'({rvalid, data_o}), 32'({1'b1, 8'h2C}));
    rd(13);
    check("load_rd13", 32'({rvalid, data_o}), 32'({1'b1, 8'h00}));

    // Overflow: 17 words offered, no last
    begin_load();
    for (int i = 0; i < DEPTH; i++) idle();
    for (int i = 1; i <= 17; i++) begin
      push(i, 0);
      if (i == 16) check("ovf_count", 32'(cnt), 32'd16);
      if (i == 17) check("ovf_ready_on_17th", 32'({ready, busy}), 32'b00);
    end
    check("ovf_count_hold", 32'(cnt), 32'd16);
    rd(15);
    check("ovf_rd15", 32'(data_o), 32'h10);

    // CPU access table
    for (int i = 0; i < 9; i++) begin
      drive(0, tbl[i].cen, tbl[i].we, int'(tbl[i].addr), int'(tbl[i].d), 0, 0, 0, 0);
      check($sformatf("tbl%0d_rvalid", i), 32'(rvalid), 32'(tbl[i].rv));
      check($sformatf("tbl%0d_data", i), 32'(data_o), 32'(tbl[i].exp_d));
    end

    // CPU access locked out while busy
    begin_load();
    wr(2, 8'h55);
    check("lock_wr_rvalid", 32'(rvalid), 32'd0);
    rd(2);
    check("lock_rd_rvalid", 32'(rvalid), 32'd0);
    for (int i = 0; i < DEPTH - 2; i++) idle();
    push(8'h77, 1);
    check("lock_count", 32'({busy, cnt}), 32'd1);
    rd(2);
    check("lock_rd2", 32'(data_o), 32'h00);
    rd(0);
    check("lock_rd0", 32'(data_o), 32'h77);

    // Reset in the middle of a load
    begin_load();
    for (int i = 0; i < DEPTH; i++) idle();
    for (int i = 0; i < 5; i++) push(8'h11 + i, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    check("midrst_state", 32'({busy, ready, cnt}), 32'd0);
    for (int i = 0; i <= 5; i++) begin
      rd(i);
      check($sformatf("midrst_rd%0d", i), 32'(data_o), (i < 5) ? 32'(8'h11 + i) : 32'd0);
    end

    // Randomized run against the model
    for (int i = 0; i < 1500; i++) begin
      drive($urandom_range(0, 299) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
            int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 255)),
            $urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0,
            int'($urandom_range(0, 255)), $urandom_range(0, 9) == 0);
    end
    for (int i = 0; i < 60; i++) push(0, 1);

`ifdef SAP_PROG_RAM_PARITY_EN
    // Parity: corrupted write then clean neighbour
    err_inject = 1'b1;
    wr(2, 8'h3C);
    err_inject = 1'b0;
    check("par_wr_flag", 32'(parity_err), 32'd0);
    rd(2);
    check("par_rd2", 32'({rvalid, parity_err, data_o}), 32'({1'b1, 1'b1, 8'h3C}));
    wr(3, 8'h81);
    rd(3);
    check("par_rd3", 32'({rvalid, parity_err}), 32'b10);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sap_prog_ram.md
Name: sap_prog_ram

Overview:
- Parametrised single-port program/data RAM for the next-generation SAP CPU.
- Replaces the fixed 16x8 asynchronous-read ROM-style memory with:
  - synchronous read and write,
  - a streaming loader with an auto-incrementing pointer,
  - an optional clear-before-load sweep.
- Sits between the CPU bus (MAR/RAM-out path) and a host/boot loader that streams the program image before run.

Parameters:
- DATA_W, 8, word width in bits.
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W words (local, derived).
- CLEAR_ON_PROG, 1, 1 = zero the whole array before each load; 0 = load directly over existing contents.

Ports:
- clk_i  in  1  single clock; all logic on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- cen_i  in  1  CPU access enable.
- we_i  in  1  CPU write when cen_i=1; read when cen_i=1 and we_i=0.
- addr_i  in  ADDR_W  CPU address.
- data_i  in  DATA_W  CPU write data.
- data_o  out  DATA_W  registered read data.
- rvalid_o  out  1  one-cycle pulse, data_o valid.
- prog_start_i  in  1  pulse; start a load session.
- prog_valid_i  in  1  loader word valid.
- prog_data_i  in  DATA_W  loader word.
- prog_last_i  in  1  qualifies the final loader word.
- prog_ready_o  out  1  loader may transfer.
- busy_o  out  1  high in CLEAR or PROG.
- prog_count_o  out  ADDR_W+1  words accepted in the current/last session.

Behaviour:
- Interface: one clock (clk_i); reset rst_i is synchronous and active-high.
- Reset values:
  - Outputs: data_o=0, rvalid_o=0, prog_ready_o=0, busy_o=0, prog_count_o=0.
  - Internal: FSM=RUN, pointer=0.
  - The memory array is NOT reset.
- FSM states: RUN, CLEAR, PROG.
- RUN:
  - Read: cen_i=1, we_i=0 → mem[addr_i] appears on data_o the next cycle with rvalid_o=1. Latency is exactly 1.
  - Write: cen_i=1, we_i=1 → mem[addr_i]<=data_i; no rvalid_o.
  - data_o holds its value when there is no read.
  - prog_start_i=1 → CLEAR if CLEAR_ON_PROG=1, else PROG.
  - On that transition, pointer<=0 and prog_count_o<=0.
- CLEAR:
  - Writes 0 to address pointer, pointer++, one word per cycle.
  - After address DEPTH-1 is written: pointer<=0 and go to PROG. CLEAR lasts exactly DEPTH cycles.
  - prog_ready_o=0.
- PROG:
  - prog_ready_o=1.
  - Transfer occurs when prog_valid_i & prog_ready_o: mem[pointer]<=prog_data_i, pointer++, prog_count_o++.
  - The transfer with prog_last_i=1 → RUN on the next cycle.
  - The transfer writing address DEPTH-1 → RUN regardless of prog_last_i; prog_count_o=DEPTH, so it saturates and the pointer never wraps.
  - prog_ready_o drops in the cycle after the final transfer.
  - prog_valid_i=0 → no state change; wait indefinitely.
- busy_o=1 exactly while in CLEAR or PROG.
- CPU access while busy: ignored. No write, no rvalid_o, data_o holds.
- prog_start_i while busy: ignored.
- cen_i and prog_start_i in the same RUN cycle: the CPU access completes (read data returned next cycle), and the FSM transitions.
- prog_count_o holds after returning to RUN until the next prog_start_i or reset.
- Reset mid-CLEAR/PROG: FSM→RUN, count=0. Words already written are retained; the remaining words keep their prior contents.

Optional Feature:
- Macro: SAP_PROG_RAM_PARITY_EN.
- Defined:
  - Each word stores one extra even-parity bit, computed on every write (CPU, loader, clear).
  - Extra output parity_err_o (1 bit, reset 0), updated with rvalid_o: it is 1 if the stored parity mismatches on the read, and it is 0 on every cycle where rvalid_o=0.
  - Extra input err_inject_i (1 bit): when high during any write, the stored parity bit is inverted.
- Not defined: no parity storage and neither port exists. Behaviour is otherwise identical.

Test Plan:
- Load: rst, prog_start_i, CLEAR_ON_PROG=1 → busy_o high 16 CLEAR cycles. Then stream 13 words 0x09,0x1A,0x1B,0x2C,0xE0,0xF0,0x00,0x00,0x00,0x10,0x14,0x18,0x20 with prog_last_i on the 13th → RUN, prog_count_o=13. Read addr 3 → data_o=0x2C, rvalid_o=1 one cycle later. Read addr 13 → 0x00.
- Overflow: stream 17 words 0x01..0x11, no prog_last_i → RUN after the 16th, prog_count_o=16, prog_ready_o=0 when the 17th is offered. addr 15 reads 0x10.
- CPU R/W: write 0xA5 to addr 7, read addr 7 next cycle → data_o=0xA5 with rvalid_o one cycle after the read. No rvalid_o on the write cycle.
- Busy lockout: during CLEAR, cen_i=1 we_i=1 addr 2 data 0x55, then a read → no rvalid_o. After the load (last on word 1 = 0x77), addr 2 reads 0x00.
- Reset mid-PROG: after 5 words 0x11..0x15 assert rst_i → busy_o=0, prog_count_o=0. addr 0..4 read 0x11..0x15; addr 5 reads 0x00 (cleared).
- Parity (macro defined): CPU write 0x3C to addr 2 with err_inject_i=1, then read addr 2 → data_o=0x3C, parity_err_o=1. Read addr 3 → parity_err_o=0.
